mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_LAT, default 1, meaning the RAM read latency in clock edges from ram_addr valid to ram_dout valid (legal range 1..7).
REQ-002 SHALL have parameter IO_BASE, default 16'hFF00, meaning addresses >= IO_BASE target the I/O port and all lower addresses target RAM.
REQ-003 SHALL have port clk, input, 1, the single clock; every register samples on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset; 0 resets the block.
REQ-005 SHALL have port memread, input, 1, read request from the control state machine.
REQ-006 SHALL have port memwrite, input, 1, write request from the control state machine.
REQ-007 SHALL have port addr, input, 16, request address.
REQ-008 SHALL have port wdata, input, 16, write data.
REQ-009 SHALL have port rdata, output, 16, read data, valid while ready=1 and held until the next read completes.
REQ-010 SHALL have port ready, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1, high whenever the block is not in IDLE.
REQ-012 SHALL have port err, output, 1, sticky protocol-error flag.
REQ-013 SHALL have RAM-side ports: ram_addr (output, 16), ram_din (output, 16), ram_we (output, 1), ram_dout (input, 16).
REQ-014 SHALL have I/O-side ports: io_re (output, 1), io_we (output, 1), io_rdata (input, 16); the I/O port reuses ram_addr and ram_din for address and data.

Function
REQ-015 SHALL implement states IDLE, RD_WAIT, RD_DONE, WR, IO_RD and IO_WR, with all outputs registered.
REQ-016 In IDLE, SHALL sample requests at each edge (E0) and capture addr and wdata into ram_addr and ram_din at E0.
REQ-017 SHALL route a RAM read to RD_WAIT, a RAM write to WR, an I/O read to IO_RD, and an I/O write to IO_WR.
REQ-018 When memread and memwrite are both 1 in IDLE, SHALL perform the read only, discard the write, and set err.
REQ-019 RD_WAIT SHALL count RAM_LAT edges and then go to RD_DONE.
REQ-020 RD_DONE SHALL load ram_dout into rdata, pulse ready for one cycle, and return to IDLE.
REQ-021 RAM read latency with RAM_LAT=1: ready SHALL be high between edges E0+2 and E0+3.
REQ-022 WR SHALL drive ram_we=1 for exactly one cycle (E0 to E1), assert ready from E1 to E2, and leave rdata unchanged.
REQ-023 IO_RD SHALL drive io_re=1 from E0 to E1, capture io_rdata at E1 into rdata, and assert ready from E1 to E2.
REQ-024 IO_WR SHALL drive io_we=1 from E0 to E1 and assert ready from E1 to E2.
REQ-025 SHALL never assert ram_we and io_we in the same cycle.
REQ-026 SHALL assert at most one of ram_we, io_we and io_re per transaction.
REQ-027 Any request while busy=1 SHALL be ignored and SHALL set err; no queuing.
REQ-028 err SHALL clear only on reset.
REQ-029 Address boundary: addr=IO_BASE-1 SHALL go to RAM; addr=IO_BASE and 16'hFFFF SHALL go to I/O.
REQ-030 The RD_WAIT counter SHALL be 3 bits, SHALL reset to 0 on every entry, and SHALL NOT wrap.
REQ-031 A request sampled in the same cycle as ready=1 SHALL be accepted, because the block is back in IDLE at that edge (back-to-back operation).

Reset
REQ-032 While reset=0, SHALL asynchronously force state=IDLE, rdata=0, ready=0, busy=0, err=0, ram_we=0, io_we=0, io_re=0, ram_addr=0, ram_din=0.
REQ-033 Reset mid-transaction SHALL abort the transaction with no ready pulse; ram_we and io_we SHALL drop immediately, so the write does not commit if reset precedes E1.
REQ-034 The first request SHALL be accepted at the first rising edge after reset returns to 1.

Verification
REQ-035 RAM write then read: memwrite addr=16'h0010 wdata=16'hBEEF, then memread addr=16'h0010 -> ram_we pulses once, then ready with rdata=16'hBEEF at E0+2.
REQ-036 I/O boundary: memread addr=16'hFEFF -> ram path used; memread addr=16'hFF00 with io_rdata=16'h00A5 -> io_re pulses once, then rdata=16'h00A5 at E0+1, and ram_we stays 0 throughout.
REQ-037 Simultaneous request: memread=memwrite=1 at addr=16'h0004 -> read completes, no ram_we, err=1 and err stays 1.
REQ-038 Request while busy: a second memread during RD_WAIT -> ignored, exactly one ready pulse, err=1.
REQ-039 Reset mid-write: reset=0 asserted during the WR cycle -> ram_we falls to 0 immediately, no ready, all outputs 0.
REQ-040 Latency sweep: RAM_LAT=3, memread -> ready at E0+4, and back-to-back reads issued on the ready cycle both complete.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response and RAM/IO-side bus bundle for mem_responder.
interface mem_responder_if;
  localparam int unsigned DW = 16;

  logic          memread;
  logic          memwrite;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          busy;
  logic          err;
  logic [DW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic          io_re;
  logic          io_we;
  logic [DW-1:0] io_rdata;

  // Requester plus RAM/IO environment side
  modport master (
    output memread, memwrite, addr, wdata, ram_dout, io_rdata,
    input  rdata, ready, busy, err, ram_addr, ram_din, ram_we, io_re, io_we
  );

  // Responder side
  modport slave (
    input  memread, memwrite, addr, wdata, ram_dout, io_rdata,
    output rdata, ready, busy, err, ram_addr, ram_din, ram_we, io_re, io_we
  );
endinterface

// File: rtl/mem_responder.sv
// Single-transaction memory responder: routes requests to a fixed-latency RAM
// or to a one-cycle I/O port by address, with registered outputs.
module mem_responder #(
  parameter int unsigned RAM_LAT = 1,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAST = CW'(RAM_LAT - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR, IO_RD, IO_WR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          ram_we_q, ram_we_d;
  logic          io_we_q, io_we_d;
  logic          io_re_q, io_re_d;
  logic          req_c;
  logic          is_io_c;

  assign req_c   = bus.memread | bus.memwrite;
  assign is_io_c = (bus.addr >= IO_BASE);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ready_d    = 1'b0;
    err_d      = err_q;
    ram_we_d   = 1'b0;
    io_we_d    = 1'b0;
    io_re_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          ram_addr_d = bus.addr;
          ram_din_d  = bus.wdata;
          // A read wins over a simultaneous write; the write is dropped.
          if (bus.memread) begin
            if (bus.memwrite) err_d = 1'b1;
            if (is_io_c) begin
              state_d = IO_RD;
              io_re_d = 1'b1;
            end else begin
              state_d = RD_WAIT;
              cnt_d   = '0;
            end
          end else if (is_io_c) begin
            state_d = IO_WR;
            io_we_d = 1'b1;
          end else begin
            state_d  = WR;
            ram_we_d = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == LAST) state_d = RD_DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      RD_DONE: begin
        rdata_d = bus.ram_dout;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      IO_RD: begin
        rdata_d = bus.io_rdata;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      WR, IO_WR: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // No queuing: anything arriving mid-transaction is dropped and flagged.
    if ((state_q != IDLE) && req_c) err_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ram_we_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_re_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ram_we_q   <= ram_we_d;
      io_we_q    <= io_we_d;
      io_re_q    <= io_re_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.io_we    = io_we_q;
  assign bus.io_re    = io_re_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (RAM_LAT=1 and RAM_LAT=3) with behavioural RAMs.
module tb_mem_responder;
  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_we_a = 0, n_iore_a = 0, n_iowe_a = 0, n_rdy_a = 0, n_rdy_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.RAM_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mem_responder #(.RAM_LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM A: unwritten words read as addr ^ 16'h5A5A, one-edge latency
  bit   [15:0] mem_a [0:65535];
  bit          wr_a  [0:65535];
  logic [15:0] pa;
  always @(posedge clk) begin
    if (bus_a.ram_we) begin
      mem_a[bus_a.ram_addr] <= bus_a.ram_din;
      wr_a[bus_a.ram_addr]  <= 1'b1;
    end
    pa <= wr_a[bus_a.ram_addr] ? mem_a[bus_a.ram_addr] : (bus_a.ram_addr ^ 16'h5A5A);
  end
  assign bus_a.ram_dout = pa;

  // RAM B: read-only pattern, three-edge latency
  logic [15:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    pb0 <= bus_b.ram_addr ^ 16'h5A5A;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign bus_b.ram_dout = pb2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Issue one request at a negedge, hold it over one rising edge (E0); lat<0 means no response expected
  task automatic req(input bit which, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_d, input int lat);
    exp_t e;
    e.data = exp_d;
    e.cyc  = cyc + 1 + lat;
    if (!which) begin
      bus_a.memread = rd; bus_a.memwrite = wr; bus_a.addr = a; bus_a.wdata = d;
      if (lat > 0) q_a.push_back(e);
    end else begin
      bus_b.memread = rd; bus_b.memwrite = wr; bus_b.addr = a; bus_b.wdata = d;
      if (lat > 0) q_b.push_back(e);
    end
    @(negedge clk);
    bus_a.memread = 1'b0; bus_a.memwrite = 1'b0;
    bus_b.memread = 1'b0; bus_b.memwrite = 1'b0;
  endtask

  // Pulse counters, sampled on the edge that ends each pulse
  initial forever begin
    @(posedge clk);
    if (bus_a.ram_we) n_we_a++;
    if (bus_a.io_re)  n_iore_a++;
    if (bus_a.io_we)  n_iowe_a++;
    if (bus_a.ready)  n_rdy_a++;
    if (bus_b.ready)  n_rdy_b++;
  end

  // Monitor: pop and compare whenever a responder completes
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus_a.ready) begin
      if (q_a.size() == 0) check("a_spurious_ready", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("a_rdata", 32'(bus_a.rdata), 32'(e.data));
        check("a_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bus_b.ready) begin
      if (q_b.size() == 0) check("b_spurious_ready", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check("b_rdata", 32'(bus_b.rdata), 32'(e.data));
        check("b_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bus_a.ram_we || bus_a.io_we)
      check("a_we_exclusive", 32'(bus_a.ram_we & bus_a.io_we), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy0;
    reset = 1'b0;
    bus_a.memread = 1'b0; bus_a.memwrite = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.memread = 1'b0; bus_b.memwrite = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
    bus_a.io_rdata = '0;
    bus_b.io_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({bus_a.rdata, bus_a.ready, bus_a.busy, bus_a.err,
                                bus_a.ram_we, bus_a.io_we, bus_a.io_re}), 32'd0);
    check("reset_ram_bus", {bus_a.ram_addr, bus_a.ram_din}, 32'd0);

    // RAM write right after reset release, then read it back on the ready cycle
    reset = 1'b1;
    req(0, 0, 1, 16'h0010, 16'hBEEF, 16'h0000, 1);
    check("wr_ram_we_high", 32'(bus_a.ram_we), 32'd1);
    check("wr_busy", 32'(bus_a.busy), 32'd1);
    @(negedge clk);
    req(0, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 2);
    check("wr_ram_we_once", 32'(n_we_a), 32'd1);
    repeat (2) @(negedge clk);

    // Boundary: IO_BASE-1 is RAM, IO_BASE and FFFF are I/O
    req(0, 1, 0, 16'hFEFF, 16'h0000, 16'hA4A5, 2);
    check("ram_side_no_io_re", 32'(bus_a.io_re), 32'd0);
    repeat (2) @(negedge clk);
    bus_a.io_rdata = 16'h00A5;
    req(0, 1, 0, 16'hFF00, 16'h0000, 16'h00A5, 1);
    check("io_rd_io_re_high", 32'(bus_a.io_re), 32'd1);
    check("io_rd_addr", 32'(bus_a.ram_addr), 32'h0000FF00);
    @(negedge clk);
    req(0, 0, 1, 16'hFFFF, 16'h5A5A, 16'h00A5, 1);
    check("io_wr_io_we_high", 32'(bus_a.io_we), 32'd1);
    check("io_wr_ram_we_low", 32'(bus_a.ram_we), 32'd0);
    check("io_wr_din", 32'(bus_a.ram_din), 32'h00005A5A);
    @(negedge clk);
    check("io_re_once", 32'(n_iore_a), 32'd1);
    check("err_clean", 32'(bus_a.err), 32'd0);

    // Simultaneous read and write: read only, err set and sticky
    req(0, 1, 1, 16'h0004, 16'h7777, 16'h5A5E, 2);
    repeat (2) @(negedge clk);
    check("both_err_set", 32'(bus_a.err), 32'd1);
    repeat (3) @(negedge clk);
    check("both_err_sticky", 32'(bus_a.err), 32'd1);
    check("both_no_ram_we", 32'(n_we_a), 32'd1);
    check("io_we_once", 32'(n_iowe_a), 32'd1);

    reset = 1'b0;
    #1;
    check("err_cleared_by_reset", 32'(bus_a.err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Request while busy is dropped and flagged
    rdy0 = n_rdy_a;
    req(0, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 2);
    req(0, 1, 0, 16'h0020, 16'h0000, 16'h0000, -1);
    repeat (4) @(negedge clk);
    check("busy_one_ready", 32'(n_rdy_a - rdy0), 32'd1);
    check("busy_err_set", 32'(bus_a.err), 32'd1);

    // Reset during the write cycle: write aborted, no ready, outputs cleared
    rdy0 = n_rdy_a;
    req(0, 0, 1, 16'h0030, 16'hDEAD, 16'h0000, -1);
    check("abort_ram_we_high", 32'(bus_a.ram_we), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_outputs", 32'({bus_a.rdata, bus_a.ready, bus_a.busy, bus_a.err,
                                bus_a.ram_we, bus_a.io_we, bus_a.io_re}), 32'd0);
    check("abort_ram_bus", {bus_a.ram_addr, bus_a.ram_din}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_no_ready", 32'(n_rdy_a - rdy0), 32'd0);
    reset = 1'b1;
    req(0, 1, 0, 16'h0030, 16'h0000, 16'h5A6A, 2);
    repeat (3) @(negedge clk);

    // RAM_LAT=3: ready at E0+4, back-to-back read issued on the ready cycle
    req(1, 1, 0, 16'h0040, 16'h0000, 16'h5A1A, 4);
    repeat (4) @(negedge clk);
    req(1, 1, 0, 16'h0041, 16'h0000, 16'h5A1B, 4);
    repeat (6) @(negedge clk);
    check("b_two_ready", 32'(n_rdy_b), 32'd2);
    check("b_err_clean", 32'(bus_b.err), 32'd0);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
